// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over req/ack and hands them to
// decode over valid/ready, then steps the PC using the resolved branch/jump controls.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        branch_i,
  input  logic        cond_i,
  input  logic        jump_i,
  output logic        fetch_err_o,
  output logic [31:0] instr_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam bit          TO_EN_C   = (TIMEOUT != 32'd0);
  localparam logic [31:0] TO_LAST_C = 32'(TIMEOUT) - 32'd1;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic [31:0] tcnt_r;
  logic [31:0] cnt_r;
  logic [31:0] next_pc_s;

  // Jump beats taken branch beats sequential; all sums wrap modulo 2^32.
  function automatic logic [31:0] calc_next_pc(input logic [31:0] pc,
                                               input logic [31:0] instr,
                                               input logic        br,
                                               input logic        cd,
                                               input logic        jp);
    logic [31:0] pc4;
    logic [31:0] result;
    pc4 = pc + 32'd4;
    if (jp) begin
      result = {pc4[31:28], instr[25:0], 2'b00};
    end else if (br && cd) begin
      result = pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    end else begin
      result = pc4;
    end
    return result;
  endfunction

  // Next-PC candidate; only consumed in the accepting HOLD cycle.
  always_comb begin
    next_pc_s = calc_next_pc(pc_r, instr_r, branch_i, cond_i, jump_i);
  end

  // Fetch FSM with PC, instruction, timeout and retired-count registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC;
      instr_r <= 32'd0;
      tcnt_r  <= 32'd0;
      cnt_r   <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= FETCH;
        end
        FETCH: begin
          if (imem_ack_i) begin
            instr_r <= imem_rdata_i;
            state_r <= HOLD;
          end else if (TO_EN_C && (tcnt_r == TO_LAST_C)) begin
            state_r <= ERR;
          end else begin
            tcnt_r <= tcnt_r + 32'd1;
          end
        end
        HOLD: begin
          if (instr_ready_i) begin
            pc_r    <= next_pc_s;
            cnt_r   <= cnt_r + 32'd1;
            tcnt_r  <= 32'd0;
            state_r <= FETCH;
          end else begin
            state_r <= HOLD;
          end
        end
        ERR: begin
          state_r <= ERR;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Handshake flags decode straight from the state register so reset drops them at once.
  assign imem_req_o    = (state_r == FETCH);
  assign instr_valid_o = (state_r == HOLD);
  assign fetch_err_o   = (state_r == ERR);
  assign imem_addr_o   = pc_r;
  assign pc_o          = pc_r;
  assign instr_o       = instr_r;
  assign instr_cnt_o   = cnt_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: expected fetch addresses and
// presented instructions come from a behavioural next-PC model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] RST_PC2 = 32'h1000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, imem_ack, instr_ready, br, cd, jp;
  logic [31:0] imem_rdata;
  logic        imem_req, instr_valid, fetch_err;
  logic [31:0] imem_addr, instr, pc, instr_cnt;

  logic        rst2_n, ack2, ready2, br2, cd2, jp2;
  logic [31:0] rdata2;
  logic        req2, valid2, err2;
  logic [31:0] addr2, instr2, pc2, cnt2;

  instr_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(4)) u_dut (
    .clk_i(clk), .rst_i(rst_n),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_o(instr), .pc_o(pc),
    .branch_i(br), .cond_i(cd), .jump_i(jp),
    .fetch_err_o(fetch_err), .instr_cnt_o(instr_cnt)
  );

  instr_fetch_unit #(.RESET_PC(RST_PC2), .TIMEOUT(0)) u_dut2 (
    .clk_i(clk), .rst_i(rst2_n),
    .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_ack_i(ack2), .imem_rdata_i(rdata2),
    .instr_valid_o(valid2), .instr_ready_i(ready2),
    .instr_o(instr2), .pc_o(pc2),
    .branch_i(br2), .cond_i(cd2), .jump_i(jp2),
    .fetch_err_o(err2), .instr_cnt_o(cnt2)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_cnt_q[$];
  logic [31:0] exp_ipc_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] m_pc, m_instr, m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference next PC from the ISA rules, using masks and signed integer offsets.
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                             input logic b, input logic c, input logic j);
    logic [31:0] seq;
    int imm;
    seq = p + 32'd4;
    imm = int'($signed(w[15:0]));
    if (j) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (b && c) return seq + 32'(imm * 4);
    return seq;
  endfunction

  // Monitor: every new request and every new presentation pops one expectation.
  logic prev_req = 1'b0;
  logic prev_valid = 1'b0;
  always @(posedge clk) begin
    #1;
    if (imem_req && !prev_req) begin
      if (exp_addr_q.size() == 0) begin
        chk("unexpected_req", imem_addr, 32'hDEAD_BEEF);
      end else begin
        chk("fetch_addr", imem_addr, exp_addr_q.pop_front());
        chk("instr_cnt", instr_cnt, exp_cnt_q.pop_front());
      end
    end
    if (instr_valid && !prev_valid) begin
      if (exp_instr_q.size() == 0) begin
        chk("unexpected_valid", instr, 32'hDEAD_BEEF);
      end else begin
        chk("present_pc", pc, exp_ipc_q.pop_front());
        chk("present_instr", instr, exp_instr_q.pop_front());
      end
    end
    prev_req   = imem_req;
    prev_valid = instr_valid;
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0; instr_ready = 1'b0; br = 1'b0; cd = 1'b0; jp = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_pc", pc, RST_PC);
    chk("rst_instr", instr, 32'd0);
    chk("rst_cnt", instr_cnt, 32'd0);
    rst_n = 1'b1;
    m_pc = RST_PC;
    m_cnt = 32'd0;
    exp_addr_q.push_back(RST_PC);
    exp_cnt_q.push_back(32'd0);
  endtask

  // One instruction: ack after d wait cycles, stall rd cycles with noise, then accept.
  task automatic do_instr(input int d, input logic [31:0] word, input int rd,
                          input logic b, input logic c, input logic j);
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      chk("req_wait", 32'(imem_req), 32'd1);
      return;
    end
    repeat (d) @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = word;
    m_instr = word;
    exp_ipc_q.push_back(m_pc);
    exp_instr_q.push_back(word);
    @(negedge clk);
    imem_ack = 1'b0;
    for (int i = 0; i < rd; i++) begin
      br = 1'($urandom); cd = 1'($urandom); jp = 1'($urandom);
      imem_ack = 1'($urandom); imem_rdata = $urandom;
      @(negedge clk);
      chk("stall_instr", instr, m_instr);
      chk("stall_pc", pc, m_pc);
      chk("stall_cnt", instr_cnt, m_cnt);
      chk("stall_req", 32'(imem_req), 32'd0);
    end
    imem_ack = 1'b0;
    br = b; cd = c; jp = j;
    instr_ready = 1'b1;
    m_pc = model_next(m_pc, m_instr, b, c, j);
    m_cnt = m_cnt + 32'd1;
    exp_addr_q.push_back(m_pc);
    exp_cnt_q.push_back(m_cnt);
    @(negedge clk);
    instr_ready = 1'b0; br = 1'b0; cd = 1'b0; jp = 1'b0;
  endtask

  task automatic chk_next(input string name, input logic [31:0] exp);
    chk({name, "_req"}, 32'(imem_req), 32'd1);
    chk(name, imem_addr, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    imem_rdata = 32'd0;
    rst2_n = 1'b0; ack2 = 1'b0; ready2 = 1'b0; br2 = 1'b0; cd2 = 1'b0; jp2 = 1'b0;
    rdata2 = 32'd0;
    apply_reset();

    // Zero-wait sequential stream: request must already be up on cycles 1,3,5,7.
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("req_on_time", 32'(imem_req), 32'd1);
      do_instr(0, $urandom, 0, 1'b0, 1'b0, 1'b0);
    end
    chk("cnt_after_4", instr_cnt, 32'd4);

    do_instr(0, 32'h0800_0010, 0, 1'b0, 1'b0, 1'b1);  chk_next("jump_to_40", 32'h0000_0040);
    do_instr(0, 32'h1000_0003, 0, 1'b1, 1'b1, 1'b0);  chk_next("beq_taken", 32'h0000_0050);
    do_instr(1, 32'h0800_0010, 0, 1'b0, 1'b0, 1'b1);  chk_next("jump_back", 32'h0000_0040);
    do_instr(0, 32'h1000_0003, 0, 1'b1, 1'b0, 1'b0);  chk_next("beq_not_taken", 32'h0000_0044);
    do_instr(0, 32'h0800_0010, 0, 1'b0, 1'b0, 1'b1);  chk_next("jump_again", 32'h0000_0040);
    do_instr(0, 32'h0000_FFFF, 0, 1'b1, 1'b1, 1'b0);  chk_next("branch_self", 32'h0000_0040);
    do_instr(2, 32'h1000_0003, 5, 1'b0, 1'b0, 1'b0);  chk_next("after_stall", 32'h0000_0044);
    do_instr(0, 32'h1000_FFED, 0, 1'b1, 1'b1, 1'b0);  chk_next("branch_neg", 32'hFFFF_FFFC);
    do_instr(0, $urandom, 0, 1'b0, 1'b0, 1'b0);       chk_next("pc_wrap", 32'h0000_0000);
    do_instr(3, $urandom, 0, 1'b0, 1'b0, 1'b0);       chk_next("ack_4th_cycle", 32'h0000_0004);

    for (int k = 0; k < 40; k++) begin
      do_instr(int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 2)),
               1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a fetch must drop the request without a clock edge.
    do_instr(0, 32'h0800_0010, 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req_drop", 32'(imem_req), 32'd0);
    chk("async_pc_reset", imem_addr, RST_PC);
    apply_reset();

    // Timeout: no ack for four fetch cycles lands in a sticky error.
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("to_cycle4_req", 32'(imem_req), 32'd1);
    chk("to_cycle4_err", 32'(fetch_err), 32'd0);
    @(negedge clk);
    chk("to_err", 32'(fetch_err), 32'd1);
    chk("to_req_low", 32'(imem_req), 32'd0);
    imem_ack = 1'b1; instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(fetch_err), 32'd1);
    chk("err_no_valid", 32'(instr_valid), 32'd0);
    apply_reset();
    do_instr(1, $urandom, 1, 1'b0, 1'b0, 1'b0);
    chk_next("post_err_seq", RST_PC + 32'd4);
    repeat (2) @(negedge clk);
    chk("queues_drained", 32'(exp_addr_q.size() + exp_instr_q.size()), 32'd0);

    // Second unit: timeout disabled, jump wins over a taken branch in a high segment.
    rst2_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("nto_err", 32'(err2), 32'd0);
    chk("nto_req", 32'(req2), 32'd1);
    chk("nto_addr", addr2, RST_PC2);
    ack2 = 1'b1; rdata2 = 32'h0800_0010;
    @(negedge clk);
    ack2 = 1'b0;
    chk("nto_valid", 32'(valid2), 32'd1);
    chk("nto_instr", instr2, 32'h0800_0010);
    ready2 = 1'b1; jp2 = 1'b1; br2 = 1'b1; cd2 = 1'b1;
    @(negedge clk);
    ready2 = 1'b0; jp2 = 1'b0; br2 = 1'b0; cd2 = 1'b0;
    chk("prio_addr", addr2, 32'h1000_0040);
    chk("prio_cnt", cnt2, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch unit for the multi-cycle MIPS core: owns the PC, fetches 32-bit instruction words from instruction memory over a req/ack handshake, and presents each word to the decode stage with a valid/ready handshake. On acceptance it consumes that instruction's resolved control signals, branch/jump/condition, and computes the next PC from them. It closes the loop between the opcode decoder's control outputs and the instruction stream that feeds the decoder.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `TIMEOUT`, default 16: maximum FETCH cycles to wait for `imem_ack_i`; 0 disables the timeout.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: asynchronous, active-low reset.
- `imem_req_o` output 1: fetch request to instruction memory.
- `imem_addr_o` output 32: fetch byte address; always equals the current PC.
- `imem_ack_i` input 1: memory response valid; `imem_rdata_i` is valid in the same cycle.
- `imem_rdata_i` input 32: fetched instruction word.
- `instr_valid_o` output 1: `instr_o` and `pc_o` are valid for decode.
- `instr_ready_i` input 1: decode accepts the instruction; resolution inputs are valid in this cycle.
- `instr_o` output 32: held instruction word.
- `pc_o` output 32: address of `instr_o`.
- `branch_i` input 1: the accepted instruction is a conditional branch (beq/bne/blez/bgtz).
- `cond_i` input 1: the branch condition evaluated true.
- `jump_i` input 1: the accepted instruction is j or jal.
- `fetch_err_o` output 1: sticky fetch timeout error.
- `instr_cnt_o` output 32: count of accepted instructions; wraps modulo 2^32.

## Operation
- States: IDLE, FETCH, HOLD, ERR. The state, PC, instruction, timeout counter and instruction count are all registers.
- IDLE: entered on reset. Moves to FETCH unconditionally on the next edge.
- FETCH:
  - `imem_req_o`=1 and `imem_addr_o`=PC; both stay stable until ack.
  - On `imem_ack_i`=1: capture `imem_rdata_i` into the instruction register and go to HOLD.
  - Otherwise the timeout counter increments.
- HOLD:
  - `instr_valid_o`=1 and `imem_req_o`=0; `instr_o` and `pc_o` are stable while `instr_ready_i`=0.
  - On `instr_ready_i`=1: update PC to next-PC, increment `instr_cnt_o`, clear the timeout counter, go to FETCH.
- Next-PC priority (sampled only in the accepting cycle):
  1. If `jump_i`: {PC+4[31:28], instr[25:0], 2'b00}.
  2. Else if `branch_i` and `cond_i`: PC+4 + (sign-extend(instr[15:0]) << 2).
  3. Else: PC+4.
- All additions are 32-bit modulo 2^32. PC 32'hFFFF_FFFC plus 4 wraps to 0.
- Timeout: if `TIMEOUT`>0 and ack has not arrived by the end of the TIMEOUT-th FETCH cycle, go to ERR.
  - An ack in the TIMEOUT-th cycle is accepted normally.
- ERR: `fetch_err_o`=1, `imem_req_o`=0, `instr_valid_o`=0. Only reset exits ERR.
- `imem_ack_i` outside FETCH is ignored; no state change.
- `branch_i`, `cond_i` and `jump_i` are ignored in every cycle except a HOLD cycle with `instr_ready_i`=1.
- `imem_req_o`, `instr_valid_o` and `fetch_err_o` are decoded from the state register.

## Timing
- Reset values (asynchronous, while `rst_i`=0):
  - state=IDLE, PC=`RESET_PC`, `instr_o`=0, `instr_cnt_o`=0, timeout counter=0.
  - `imem_req_o`=0, `instr_valid_o`=0, `fetch_err_o`=0; `imem_addr_o`=`pc_o`=`RESET_PC`.
- Assertion of `rst_i` mid-FETCH or mid-HOLD drops `imem_req_o` and `instr_valid_o` immediately, without waiting for a clock edge.
- First edge after reset release enters FETCH, so `imem_req_o` is high from cycle 1.
- Ack in cycle N gives `instr_valid_o`=1 in cycle N+1. Zero-wait memory (ack in the first FETCH cycle) gives valid 1 cycle after the request.
- Acceptance in cycle M gives `imem_req_o`=1 with the new PC in cycle M+1. `instr_cnt_o` shows the increment in M+1.
- Best-case throughput: 1 instruction per 2 cycles.

## Test plan
- Reset with `RESET_PC`=0, ack 0 cycles after req, ready always 1, no branches/jumps:
  - addresses issued are 0, 4, 8, 12 on cycles 1, 3, 5, 7;
  - `instr_cnt_o`=4 after the 4th acceptance.
- Hold instruction at PC=0x40, word 0x1000_0003 (beq). Accept with `branch_i`=1, `cond_i`=1:
  - next `imem_addr_o`=0x50.
  - Repeat with `cond_i`=0: next address 0x44.
- Word 0xFFFF (imm=-1) at PC=0x40, `branch_i`=1, `cond_i`=1: next address 0x40.
- Jump vs branch priority:
  - PC=0x1000_0000, word 0x0800_0010, `jump_i`=1 and `branch_i`=1, `cond_i`=1: next address 0x1000_0040.
  - PC 0xFFFF_FFFC sequential: next address 0x0000_0000.
- Backpressure:
  - hold `instr_ready_i`=0 for 5 cycles: `instr_o` and `pc_o` are stable, no new req, count unchanged;
  - toggle `branch_i`/`jump_i` during the stall: no effect.
- Timeout with `TIMEOUT`=4:
  - no ack: `fetch_err_o`=1 after the 4th FETCH cycle, req low, stuck until reset;
  - ack on the 4th cycle: normal HOLD;
  - reset asserted mid-FETCH: req drops asynchronously and the PC returns to `RESET_PC`.
